fwd_hazard_unit: RTL and testbench

//  Parametrised operand-forwarding and load-use hazard unit for the in-order pipeline.

---
 rtl/fwd_hazard_unit.sv | 100 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the in-order pipeline.
// A DEPTH-entry shift scoreboard tracks in-flight destinations; the youngest match wins.
module fwd_hazard_unit #(
    parameter int unsigned  DATA_W   = 32,
    parameter int unsigned  REG_AW   = 5,
    parameter int unsigned  DEPTH    = 3,
    parameter int unsigned  LOAD_LAT = 1,
    parameter bit           ZERO_REG = 1'b1,
    localparam int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_src_a,
    input  logic [REG_AW-1:0]       id_src_b,
    input  logic                    id_use_a,
    input  logic                    id_use_b,
    input  logic [REG_AW-1:0]       id_dst,
    input  logic                    id_wr_en,
    input  logic                    id_is_load,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       rf_data_a,
    input  logic [DATA_W-1:0]       rf_data_b,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]       op_a,
    output logic [DATA_W-1:0]       op_b,
    output logic [SEL_W-1:0]        fwd_sel_a,
    output logic [SEL_W-1:0]        fwd_sel_b,
    output logic                    stall,
    output logic [15:0]             stall_cnt
);

    logic [DEPTH-1:0]  entVld;
    logic [DEPTH-1:0]  entLoad;
    logic [REG_AW-1:0] entDst [DEPTH];
    logic              hazA;
    logic              hazB;
    logic              issue;

    // Oldest-to-youngest scan so the youngest matching entry overrides older ones.
    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        hazA      = 1'b0;
        hazB      = 1'b0;
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (entVld[i-1] && entDst[i-1] == id_src_a) begin
                fwd_sel_a = SEL_W'(i);
                hazA      = entLoad[i-1] && (i <= LOAD_LAT);
            end
            if (entVld[i-1] && entDst[i-1] == id_src_b) begin
                fwd_sel_b = SEL_W'(i);
                hazB      = entLoad[i-1] && (i <= LOAD_LAT);
            end
        end
        if (rst || !id_use_a || (ZERO_REG && id_src_a == '0)) begin
            fwd_sel_a = '0;
            hazA      = 1'b0;
        end
        if (rst || !id_use_b || (ZERO_REG && id_src_b == '0)) begin
            fwd_sel_b = '0;
            hazB      = 1'b0;
        end

        op_a = rf_data_a;
        op_b = rf_data_b;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            if (fwd_sel_a == SEL_W'(i)) op_a = stage_data[(i-1)*DATA_W +: DATA_W];
            if (fwd_sel_b == SEL_W'(i)) op_b = stage_data[(i-1)*DATA_W +: DATA_W];
        end

        stall = id_valid && !flush && !rst && (hazA || hazB);
        issue = id_valid && id_wr_en && !stall && !flush && !(ZERO_REG && id_dst == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entVld    <= '0;
            entLoad   <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                entVld[i]  <= entVld[i-1];
                entLoad[i] <= entLoad[i-1];
            end
            entVld[0]  <= issue;
            entLoad[0] <= issue && id_is_load;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Destinations are only meaningful alongside entVld, so they shift without reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = DEPTH - 1; i > 0; i--) begin
            entDst[i] <= entDst[i-1];
        end
        entDst[0] <= id_dst;
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: three instances (LOAD_LAT 1, LOAD_LAT 2, deep 33-entry)
// share decode stimulus; expected outputs are queued per step and compared before the next edge.
module tb_fwd_hazard_unit;

    localparam logic [31:0] RFA = 32'hAAAA_0001;
    localparam logic [31:0] RFB = 32'hBBBB_0002;
    localparam logic [31:0] D0  = 32'h0000_0055;
    localparam logic [31:0] D1  = 32'h1111_1111;
    localparam logic [31:0] D2  = 32'h2222_2222;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] srcA;
        logic       useA;
        logic [4:0] srcB;
        logic       useB;
        logic [4:0] dst;
        logic       wr;
        logic       load;
        logic       flush;
    } stimT;

    typedef struct packed {
        logic [1:0]  inst;
        logic [92:0] v;
    } sbT;

    logic          clk;
    logic          rst;
    logic          idValid;
    logic [4:0]    idSrcA;
    logic [4:0]    idSrcB;
    logic          idUseA;
    logic          idUseB;
    logic [4:0]    idDst;
    logic          idWrEn;
    logic          idIsLoad;
    logic          flush;
    logic [31:0]   rfDataA;
    logic [31:0]   rfDataB;
    logic [95:0]   sdSmall;
    logic [1055:0] sdBig;

    logic [31:0] opA0, opB0, opA1, opB1, opA2, opB2;
    logic [1:0]  selA0, selB0, selA1, selB1;
    logic [5:0]  selA2, selB2;
    logic        stall0, stall1, stall2;
    logic [15:0] cnt0, cnt1, cnt2;
    logic [92:0] got0, got1, got2;

    sbT sbq [$];
    int checks = 0;
    int errors = 0;

    assign got0 = {4'b0, selA0, 4'b0, selB0, opA0, opB0, stall0, cnt0};
    assign got1 = {4'b0, selA1, 4'b0, selB1, opA1, opB1, stall1, cnt1};
    assign got2 = {selA2, selB2, opA2, opB2, stall2, cnt2};

    fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .LOAD_LAT(1), .ZERO_REG(1'b1)) u0 (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_src_a(idSrcA), .id_src_b(idSrcB),
        .id_use_a(idUseA), .id_use_b(idUseB), .id_dst(idDst), .id_wr_en(idWrEn),
        .id_is_load(idIsLoad), .flush(flush), .rf_data_a(rfDataA), .rf_data_b(rfDataB),
        .stage_data(sdSmall), .op_a(opA0), .op_b(opB0), .fwd_sel_a(selA0), .fwd_sel_b(selB0),
        .stall(stall0), .stall_cnt(cnt0)
    );

    fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(3), .LOAD_LAT(2), .ZERO_REG(1'b1)) u1 (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_src_a(idSrcA), .id_src_b(idSrcB),
        .id_use_a(idUseA), .id_use_b(idUseB), .id_dst(idDst), .id_wr_en(idWrEn),
        .id_is_load(idIsLoad), .flush(flush), .rf_data_a(rfDataA), .rf_data_b(rfDataB),
        .stage_data(sdSmall), .op_a(opA1), .op_b(opB1), .fwd_sel_a(selA1), .fwd_sel_b(selB1),
        .stall(stall1), .stall_cnt(cnt1)
    );

    fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .DEPTH(33), .LOAD_LAT(32), .ZERO_REG(1'b1)) u2 (
        .clk(clk), .rst(rst), .id_valid(idValid), .id_src_a(idSrcA), .id_src_b(idSrcB),
        .id_use_a(idUseA), .id_use_b(idUseB), .id_dst(idDst), .id_wr_en(idWrEn),
        .id_is_load(idIsLoad), .flush(flush), .rf_data_a(rfDataA), .rf_data_b(rfDataB),
        .stage_data(sdBig), .op_a(opA2), .op_b(opB2), .fwd_sel_a(selA2), .fwd_sel_b(selB2),
        .stall(stall2), .stall_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stimT S(input logic valid, input logic [4:0] sa, input logic ua,
                               input logic [4:0] sb, input logic ub, input logic [4:0] d,
                               input logic wr, input logic ld, input logic fl, input logic r);
        stimT s;
        s.rst = r; s.valid = valid; s.srcA = sa; s.useA = ua; s.srcB = sb; s.useB = ub;
        s.dst = d; s.wr = wr; s.load = ld; s.flush = fl;
        return s;
    endfunction

    function automatic logic [92:0] E(input logic [5:0] sa, input logic [5:0] sb,
                                      input logic [31:0] oa, input logic [31:0] ob,
                                      input logic st, input logic [15:0] c);
        return {sa, sb, oa, ob, st, c};
    endfunction

    task automatic apply(input stimT s);
        rst = s.rst; idValid = s.valid; idSrcA = s.srcA; idUseA = s.useA;
        idSrcB = s.srcB; idUseB = s.useB; idDst = s.dst; idWrEn = s.wr;
        idIsLoad = s.load; flush = s.flush;
    endtask

    task automatic doReset();
        apply(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        stimT st [2];
        logic [92:0] x [2];
        sbT e;
        logic [92:0] g;
        st[0] = S(1, 3, 1, 4, 1, 3, 1, 1, 0, 1); x[0] = E(0, 0, RFA, RFB, 0, 0);
        st[1] = S(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); x[1] = E(0, 0, RFA, RFB, 0, 0);
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            sbq.push_back({2'd0, x[i]});
            sbq.push_back({2'd1, x[i]});
            @(negedge clk);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL reset step %0d u%0d: got %h expected %h", i, e.inst, g, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        stimT st [5];
        logic [92:0] x [5];
        sbT e;
        logic [92:0] g;
        st[0] = S(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); x[0] = E(0, 0, RFA, RFB, 0, 0);
        st[1] = S(1, 3, 1, 1, 1, 4, 1, 0, 0, 0); x[1] = E(1, 0, D0, RFB, 0, 0);
        st[2] = S(1, 3, 1, 4, 1, 0, 0, 0, 0, 0); x[2] = E(2, 1, D1, D0, 0, 0);
        st[3] = S(1, 3, 1, 4, 1, 0, 0, 0, 0, 0); x[3] = E(3, 2, D2, D1, 0, 0);
        st[4] = S(1, 4, 1, 4, 0, 0, 0, 0, 0, 0); x[4] = E(3, 0, D2, RFB, 0, 0);
        doReset();
        for (int i = 0; i < 5; i++) begin
            apply(st[i]);
            sbq.push_back({2'd0, x[i]});
            @(negedge clk);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL forward step %0d u%0d: got %h expected %h", i, e.inst, g, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stimT st [4];
        logic [92:0] x0 [4];
        logic [92:0] x1 [4];
        sbT e;
        logic [92:0] g;
        st[0] = S(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
        x0[0] = E(0, 0, RFA, RFB, 0, 0); x1[0] = E(0, 0, RFA, RFB, 0, 0);
        st[1] = S(1, 5, 1, 0, 1, 0, 0, 0, 0, 0);
        x0[1] = E(1, 0, D0, RFB, 1, 0);  x1[1] = E(1, 0, D0, RFB, 1, 0);
        st[2] = st[1];
        x0[2] = E(2, 0, D1, RFB, 0, 1);  x1[2] = E(2, 0, D1, RFB, 1, 1);
        st[3] = st[1];
        x0[3] = E(3, 0, D2, RFB, 0, 1);  x1[3] = E(3, 0, D2, RFB, 0, 2);
        doReset();
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            sbq.push_back({2'd0, x0[i]});
            sbq.push_back({2'd1, x1[i]});
            @(negedge clk);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL load_use step %0d u%0d: got %h expected %h", i, e.inst, g, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_youngest();
        stimT st [4];
        logic [92:0] x [4];
        sbT e;
        logic [92:0] g;
        st[0] = S(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); x[0] = E(0, 0, RFA, RFB, 0, 0);
        st[1] = S(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); x[1] = E(0, 0, RFA, RFB, 0, 0);
        st[2] = S(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); x[2] = E(0, 0, RFA, RFB, 0, 0);
        st[3] = S(1, 9, 1, 7, 1, 0, 0, 0, 0, 0); x[3] = E(2, 1, D1, D0, 0, 0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            sbq.push_back({2'd0, x[i]});
            @(negedge clk);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL youngest step %0d u%0d: got %h expected %h", i, e.inst, g, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_reg();
        stimT st [2];
        logic [92:0] x [2];
        sbT e;
        logic [92:0] g;
        st[0] = S(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); x[0] = E(0, 0, RFA, RFB, 0, 0);
        st[1] = S(1, 0, 1, 0, 1, 0, 0, 0, 0, 0); x[1] = E(0, 0, RFA, RFB, 0, 0);
        doReset();
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            sbq.push_back({2'd0, x[i]});
            @(negedge clk);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL zero_reg step %0d u%0d: got %h expected %h", i, e.inst, g, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        stimT st [3];
        logic [92:0] x [3];
        sbT e;
        logic [92:0] g;
        st[0] = S(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); x[0] = E(0, 0, RFA, RFB, 0, 0);
        st[1] = S(1, 5, 1, 0, 0, 6, 1, 0, 1, 0); x[1] = E(1, 0, D0, RFB, 0, 0);
        st[2] = S(1, 6, 1, 5, 1, 0, 0, 0, 0, 0); x[2] = E(0, 2, RFA, D1, 0, 0);
        doReset();
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            sbq.push_back({2'd0, x[i]});
            @(negedge clk);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL flush step %0d u%0d: got %h expected %h", i, e.inst, g, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        stimT st [4];
        logic [92:0] x [4];
        sbT e;
        logic [92:0] g;
        st[0] = S(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); x[0] = E(0, 0, RFA, RFB, 0, 0);
        st[1] = S(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); x[1] = E(1, 0, D0, RFB, 1, 0);
        st[2] = S(1, 5, 1, 0, 0, 0, 0, 0, 0, 1); x[2] = E(0, 0, RFA, RFB, 0, 1);
        st[3] = S(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); x[3] = E(0, 0, RFA, RFB, 0, 0);
        doReset();
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            sbq.push_back({2'd0, x[i]});
            sbq.push_back({2'd1, x[i]});
            @(negedge clk);
            while (sbq.size() != 0) begin
                e = sbq.pop_front();
                g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                checks++;
                if (g !== e.v) begin
                    errors++;
                    $display("FAIL reset_mid_stall step %0d u%0d: got %h expected %h", i, e.inst, g, e.v);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // A self-dependent load (LW r5,(r5)) on the 33-deep unit issues once, then stalls 32 cycles.
    // After n edges the newest load sits at entry (n-1)%33 and the count is n - ceil(n/33).
    task automatic test_saturate();
        int cps [5];
        logic [92:0] x [5];
        int next;
        sbT e;
        logic [92:0] g;
        cps[0] = 66;    x[0] = E(33, 0, 32'h1000_0020, RFB, 0, 16'd64);
        cps[1] = 67582; x[1] = E(31, 0, 32'h1000_001E, RFB, 1, 16'hFFFE);
        cps[2] = 67583; x[2] = E(32, 0, 32'h1000_001F, RFB, 1, 16'hFFFF);
        cps[3] = 67584; x[3] = E(33, 0, 32'h1000_0020, RFB, 0, 16'hFFFF);
        cps[4] = 67600; x[4] = E(16, 0, 32'h1000_000F, RFB, 1, 16'hFFFF);
        next = 0;
        doReset();
        apply(S(1, 5, 1, 0, 0, 5, 1, 1, 0, 0));
        for (int n = 1; n <= 67600; n++) begin
            @(posedge clk); #1;
            if (next < 5) begin
                if (n == cps[next]) begin
                    sbq.push_back({2'd2, x[next]});
                    while (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        g = (e.inst == 2'd0) ? got0 : (e.inst == 2'd1) ? got1 : got2;
                        checks++;
                        if (g !== e.v) begin
                            errors++;
                            $display("FAIL saturate n=%0d u%0d: got %h expected %h", n, e.inst, g, e.v);
                        end
                    end
                    next++;
                end
            end
        end
    endtask

    initial begin
        rfDataA = RFA;
        rfDataB = RFB;
        sdSmall = {D2, D1, D0};
        for (int k = 0; k < 33; k++) sdBig[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        apply(S(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_zero_reg();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
